grn_collect_arbiter: RTL and testbench

Round-robin collector that drains 32 WIDTH-bit result sources through the shared 32:1 select mux into a single valid/ready output stream. It sits between the per-core result FIFOs and the write-back path. It picks the next requesting source, drives the mux select, captures the muxed word, pops the source and buffers the word in a 2-entry output FIFO. It also raises a sticky `done` once every source has finished and all data has left the block.

---
 rtl/grn_collect_pkg.sv | 23 ++
 rtl/grn_collect_if.sv | 33 +++
 rtl/grn_collect_fifo2.sv | 43 ++++
 rtl/grn_collect_arbiter.sv | 94 +++++++++
 tb/tb_grn_collect_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/grn_collect_pkg.sv
// Shared constants, FSM state type and round-robin pick for the result collector.
package grn_collect_pkg;
   localparam int N_SRC = 32;
   localparam int SEL_W = 5;

   typedef enum logic {ARB, READ} state_e;

   // First set req bit at or above ptr, wrapping 31 -> 0.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                input logic [SEL_W-1:0] ptr);
      logic [SEL_W-1:0] idx;
      logic             found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         idx = ptr + SEL_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/grn_collect_if.sv
// Source/mux/output bundle of the collector. GRN_COLLECT_COUNT_EN adds word_count.
interface grn_collect_if #(parameter int WIDTH = 256);
   import grn_collect_pkg::*;
   logic [N_SRC-1:0] req;
   logic [N_SRC-1:0] src_done;
   logic [N_SRC-1:0] ack;
   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] mux_out;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [SEL_W-1:0] out_src;
   logic             done;
`ifdef GRN_COLLECT_COUNT_EN
   logic [31:0]      word_count;
`endif

   modport master (
      input  req, src_done, mux_out, out_ready,
`ifdef GRN_COLLECT_COUNT_EN
      output word_count,
`endif
      output ack, sel, out_valid, out_data, out_src, done
   );

   modport slave (
      output req, src_done, mux_out, out_ready,
`ifdef GRN_COLLECT_COUNT_EN
      input  word_count,
`endif
      input  ack, sel, out_valid, out_data, out_src, done
   );
endinterface

// File: rtl/grn_collect_fifo2.sv
// Two-entry FIFO; caller guarantees no push when full and no pop when empty.
module grn_collect_fifo2 #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);
   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wr_q, wr_d, rd_q, rd_d;
   logic [1:0]        cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/grn_collect_arbiter.sv
// Round-robin collector: 32 sources -> shared mux -> 2-deep valid/ready stream.
// Optional GRN_COLLECT_COUNT_EN adds a 32-bit output handshake counter.
module grn_collect_arbiter
   import grn_collect_pkg::*;
#(
   parameter int WIDTH = 256
) (
   input logic          clk,
   input logic          rst,
   grn_collect_if.master bus
);
   state_e           state_q, state_d;
   logic [SEL_W-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             done_q, done_d;
   logic [N_SRC-1:0] ack_o;
   logic             push, pop, cnt_busy;
   logic [1:0]       count;
   logic [WIDTH+SEL_W-1:0] head;

   assign pop = (count != 2'd0) && bus.out_ready;

`ifdef GRN_COLLECT_COUNT_EN
   logic [31:0] wc_q, wc_d;
   assign wc_d     = wc_q + {31'd0, pop};
   assign cnt_busy = pop;
   always_ff @(posedge clk) begin
      if (rst) wc_q <= '0;
      else     wc_q <= wc_d;
   end
   assign bus.word_count = wc_q;
`else
   assign cnt_busy = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      done_d  = done_q;
      push    = 1'b0;
      ack_o   = '0;
      case (state_q)
         ARB: begin
            // At most one word in flight, so count < 2 here rules out overflow.
            if (bus.req != '0 && count != 2'd2) begin
               gnt_d   = rr_pick(bus.req, ptr_q);
               state_d = READ;
            end
            if (bus.src_done == '1 && bus.req == '0 && count == 2'd0 && !cnt_busy)
               done_d = 1'b1;
         end
         READ: begin
            push         = 1'b1;
            // A reset landing on this cycle drops the grant without popping the source.
            ack_o[gnt_q] = !rst;
            ptr_d        = gnt_q + SEL_W'(1);
            state_d      = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
         gnt_q   <= '0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
      end
   end

   grn_collect_fifo2 #(.W(WIDTH + SEL_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({bus.mux_out, gnt_q}),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign bus.ack       = ack_o;
   assign bus.sel       = gnt_q;
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_data  = head[WIDTH+SEL_W-1:SEL_W];
   assign bus.out_src   = head[SEL_W-1:0];
   assign bus.done      = done_q;
endmodule

// File: tb/tb_grn_collect_arbiter.sv
// Scoreboard bench for grn_collect_arbiter: modelled sources, RR grant model, output queue.
module tb_grn_collect_arbiter;
   import grn_collect_pkg::*;
   localparam int WIDTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   grn_collect_if #(.WIDTH(WIDTH)) bus ();
   grn_collect_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct { logic [WIDTH-1:0] d; int s; } exp_t;
   exp_t             sb[$];
   int               glog[$];
   int               rem[N_SRC];
   int               hd[N_SRC];
   int               mptr = 0;
   int               pend = -1;
   int               total = 0;
   int               bad = 0;
   logic [N_SRC-1:0] req_smp;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] mkword(input int s, input int n);
      logic [WIDTH-1:0] w;
      for (int k = 0; k < WIDTH/32; k++) w[k*32 +: 32] = {8'(s), 16'(n), 8'(k)};
      return w;
   endfunction

   always_comb for (int i = 0; i < N_SRC; i++) bus.req[i] = (rem[i] != 0);
   always_comb bus.mux_out = mkword(int'(bus.sel), hd[bus.sel]);
   always @(posedge clk) req_smp <= bus.req;

   // Source pop model, reference round-robin and output scoreboard.
   initial forever begin
      int   g;
      exp_t e;
      @(negedge clk);
      if (pend >= 0) begin hd[pend]++; pend = -1; end
      if (rst) begin
         mptr = 0;
         sb.delete();
      end else begin
         if (bus.ack != '0) begin
            g = -1;
            for (int k = 0; k < N_SRC; k++)
               if (g < 0 && req_smp[(mptr + k) % N_SRC]) g = (mptr + k) % N_SRC;
            if (g < 0) chk("ack_spurious", bus.ack, 0);
            else begin
               chk("ack_gnt", bus.ack, (WIDTH)'(1) << g);
               sb.push_back('{mkword(g, hd[g]), g});
               glog.push_back(g);
               mptr = (g + 1) % N_SRC;
               if (rem[g] > 0) rem[g]--;
               pend = g;
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               chk("out_data", bus.out_data, e.d);
               chk("out_src", bus.out_src, e.s);
            end
         end
      end
   end

   task automatic wait_idle();
      int quiet = 0;
      for (int c = 0; c < 2000 && quiet < 4; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && bus.req == '0 && !bus.out_valid && pend < 0) quiet++;
         else quiet = 0;
      end
      if (quiet < 4) chk("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"}, bus.sel, 0);
      chk({tag, "_ack"}, bus.ack, 0);
      chk({tag, "_ovld"}, bus.out_valid, 0);
      chk({tag, "_odata"}, bus.out_data, 0);
      chk({tag, "_osrc"}, bus.out_src, 0);
      chk({tag, "_done"}, bus.done, 0);
`ifdef GRN_COLLECT_COUNT_EN
      chk({tag, "_wcnt"}, bus.word_count, 0);
`endif
   endtask

   initial begin
      int rr_exp[5] = '{31, 0, 5, 31, 5};
      bus.src_done  = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst");
      @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b1;

      // single source: ack at t+1, out_valid at t+2
      rem[4] = 1;
      @(negedge clk);
      chk("single_ack_arb", bus.ack, 0);
      @(posedge clk); @(negedge clk);
      chk("single_sel", bus.sel, 4);
      chk("single_ack", bus.ack, 32'h10);
      chk("single_ovld_t1", bus.out_valid, 0);
      @(negedge clk);
      chk("single_ack_drop", bus.ack, 0);
      chk("single_ovld", bus.out_valid, 1);
      chk("single_osrc", bus.out_src, 4);
      chk("single_odata", bus.out_data, mkword(4, 0));
      wait_idle();

      // move ptr to 6, then 0/5/31 must wrap 31,0,5,31,5
      rem[5] = 1;
      wait_idle();
      glog.delete();
      rem[0] = 1; rem[5] = 2; rem[31] = 2;
      wait_idle();
      chk("rr_count", glog.size(), 5);
      for (int i = 0; i < 5 && i < glog.size(); i++) chk($sformatf("rr_order%0d", i), glog[i], rr_exp[i]);

      // backpressure: two grants then stall
      glog.delete();
      bus.out_ready = 1'b0;
      rem[2] = 1; rem[9] = 1; rem[20] = 1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("bp_acks", glog.size(), 2);
      if (glog.size() >= 2) begin
         chk("bp_g0", glog[0], 9);
         chk("bp_g1", glog[1], 20);
      end
      chk("bp_req_left", bus.req, 32'h4);
      chk("bp_ovld", bus.out_valid, 1);
      @(posedge clk); #1 bus.out_ready = 1'b1;
      wait_idle();
      chk("bp_total", glog.size(), 3);
      if (glog.size() >= 3) chk("bp_g2", glog[2], 2);

      // done waits for the buffered word to leave
      bus.out_ready = 1'b0;
      rem[7] = 1;
      repeat (6) @(posedge clk);
      #1 bus.src_done = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("done_held", bus.done, 0);
      chk("done_ovld", bus.out_valid, 1);
      @(posedge clk); #1 bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("done_drain", bus.done, 0);
      chk("done_empty", bus.out_valid, 0);
      @(negedge clk);
      chk("done_set", bus.done, 1);
      repeat (4) @(negedge clk);
      chk("done_sticky", bus.done, 1);

      // reset landing on a READ cycle
      @(posedge clk); #1 bus.src_done = '0; rem[12] = 1;
      @(posedge clk); #1 rst = 1'b1; rem[12] = 0;
      @(negedge clk);
      chk("rst_read_ack", bus.ack, 0);
      @(posedge clk); @(negedge clk);
      chk_reset_vals("midrst");
      @(posedge clk); #1 rst = 1'b0;

      // stream 40 words with random backpressure
      glog.delete();
      for (int i = 0; i < 20; i++) rem[i] = 2;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'b1;
      wait_idle();
      chk("stream_n", glog.size(), 40);
`ifdef GRN_COLLECT_COUNT_EN
      chk("word_count", bus.word_count, 40);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
